// File: rtl/breakout_pkg.sv
// Shared constants for the Breakout VGA renderer: default raster timing,
// brick state encoding and the colour palette.
package breakout_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_IDX_W    = 6;

  typedef enum logic [1:0] {
    BRICK_FRESH = 2'd0,
    BRICK_HIT1  = 2'd1,
    BRICK_HIT2  = 2'd2,
    BRICK_DEAD  = 2'd3
  } brick_state_e;

  localparam logic [5:0] COLOR_PADDLE = 6'b100001;
  localparam logic [5:0] COLOR_BALL   = 6'b111000;
  localparam logic [5:0] COLOR_BG     = 6'b000000;

  // Base colour of a brick row; the hit count is added on top of it.
  function automatic logic [5:0] row_color(input logic [2:0] row);
    logic [5:0] color;
    case (row)
      3'd0:    color = 6'b110000;
      3'd1:    color = 6'b110100;
      3'd2:    color = 6'b111100;
      3'd3:    color = 6'b001100;
      3'd4:    color = 6'b000011;
      3'd5:    color = 6'b010011;
      3'd6:    color = 6'b100010;
      default: color = 6'b101010;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/breakout_vga_renderer_if.sv
// Bundle between the game logic and the renderer: video out, object
// positions in, brick state write port in.
interface breakout_vga_renderer_if #(
  parameter int IDX_W = 6
);

  logic             hsync;
  logic             vsync;
  logic [5:0]       RGB;
  logic [9:0]       hor_count;
  logic [9:0]       ver_count;
  logic             frame_start;
  logic [9:0]       paddle_pos;
  logic [9:0]       ball_x;
  logic [9:0]       ball_y;
  logic             active_write_enable;
  logic [IDX_W-1:0] active_position;
  logic [1:0]       active_data;

  modport master (
    output paddle_pos, ball_x, ball_y,
    output active_write_enable, active_position, active_data,
    input  hsync, vsync, RGB, hor_count, ver_count, frame_start
  );

  modport slave (
    input  paddle_pos, ball_x, ball_y,
    input  active_write_enable, active_position, active_data,
    output hsync, vsync, RGB, hor_count, ver_count, frame_start
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Raster counters with undelayed sync, line/frame end strobes and the
// frame_start pulse at the first blanking line.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       CLK_25MH,
  input  logic       reset,
  output logic [9:0] hor_count,
  output logic [9:0] ver_count,
  output logic       hsync_raw,
  output logic       vsync_raw,
  output logic       frame_start,
  output logic       line_end,
  output logic       frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_FS     = 11'(V_ACTIVE);

  logic [10:0] h_ext;
  logic [10:0] v_ext;

  assign h_ext     = {1'b0, hor_count};
  assign v_ext     = {1'b0, ver_count};
  assign line_end  = (h_ext == H_LAST);
  assign frame_end = line_end && (v_ext == V_LAST);

  always_ff @(posedge CLK_25MH) begin
    if (reset) begin
      hor_count <= '0;
      ver_count <= '0;
    end else if (line_end) begin
      hor_count <= '0;
      ver_count <= frame_end ? 10'd0 : ver_count + 10'd1;
    end else begin
      hor_count <= hor_count + 10'd1;
    end
  end

  assign hsync_raw   = !((h_ext >= HS_START) && (h_ext < HS_END));
  assign vsync_raw   = !((v_ext >= VS_START) && (v_ext < VS_END));
  assign frame_start = (hor_count == 10'd0) && (v_ext == V_FS);

endmodule

// File: rtl/breakout_vga_renderer.sv
// Breakout renderer: brick lookup via running row/column trackers, then a
// two-stage pixel pipeline that keeps hsync/vsync aligned with RGB.
module breakout_vga_renderer
  import breakout_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int NUM_ROWS    = 5,
  parameter int NUM_COLS    = 5,
  parameter int BRICK_X0    = 40,
  parameter int BRICK_W     = 80,
  parameter int BRICK_GAP_X = 40,
  parameter int BRICK_Y0    = 40,
  parameter int BRICK_H     = 30,
  parameter int ROW_PITCH   = 50,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 100,
  parameter int PADDLE_Y    = 440,
  parameter int PADDLE_H    = 10,
  parameter int IDX_W       = DEF_IDX_W
) (
  input logic               CLK_25MH,
  input logic               reset,
  breakout_vga_renderer_if.slave bus
);

  localparam logic [IDX_W:0]   BRICK_COUNT = (IDX_W + 1)'(NUM_ROWS * NUM_COLS);
  localparam logic [IDX_W-1:0] COL_LIMIT   = IDX_W'(NUM_COLS);
  localparam logic [IDX_W-1:0] ROW_LIMIT   = IDX_W'(NUM_ROWS);
  localparam logic [IDX_W-1:0] ROW_STEP    = IDX_W'(NUM_COLS);
  localparam logic [10:0] COL_X0    = 11'(BRICK_X0);
  localparam logic [10:0] COL_W     = 11'(BRICK_W);
  localparam logic [10:0] COL_LASTO = 11'(BRICK_W - 1);
  localparam logic [10:0] COL_PITCH = 11'(BRICK_W + BRICK_GAP_X);
  localparam logic [10:0] ROW_Y0    = 11'(BRICK_Y0);
  localparam logic [10:0] ROW_H     = 11'(BRICK_H);
  localparam logic [10:0] ROW_LASTO = 11'(BRICK_H - 1);
  localparam logic [10:0] ROW_STRD  = 11'(ROW_PITCH);
  localparam logic [10:0] BALL_SZ   = 11'(BALL_SIZE);
  localparam logic [10:0] PAD_W     = 11'(PADDLE_W);
  localparam logic [10:0] PAD_Y0    = 11'(PADDLE_Y);
  localparam logic [10:0] PAD_Y1    = 11'(PADDLE_Y + PADDLE_H);
  localparam logic [10:0] H_VIS     = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS     = 11'(V_ACTIVE);

  logic [9:0]  hor_count;
  logic [9:0]  ver_count;
  logic        hsync_raw;
  logic        vsync_raw;
  logic        frame_start;
  logic        line_end;
  logic        frame_end;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) timing (
    .CLK_25MH   (CLK_25MH),
    .reset      (reset),
    .hor_count  (hor_count),
    .ver_count  (ver_count),
    .hsync_raw  (hsync_raw),
    .vsync_raw  (vsync_raw),
    .frame_start(frame_start),
    .line_end   (line_end),
    .frame_end  (frame_end)
  );

  assign bus.hor_count   = hor_count;
  assign bus.ver_count   = ver_count;
  assign bus.frame_start = frame_start;

  logic [9:0] ball_x_q;
  logic [9:0] ball_y_q;
  logic [9:0] paddle_q;

  always_ff @(posedge CLK_25MH) begin
    if (reset) begin
      ball_x_q <= '0;
      ball_y_q <= '0;
      paddle_q <= '0;
    end else if (frame_start) begin
      ball_x_q <= bus.ball_x;
      ball_y_q <= bus.ball_y;
      paddle_q <= bus.paddle_pos;
    end
  end

  logic [IDX_W-1:0] col_idx;
  logic [IDX_W-1:0] row_idx;
  logic [IDX_W-1:0] row_base;
  logic [10:0]      col_lo;
  logic [10:0]      row_lo;
  logic [10:0]      h_ext;
  logic [10:0]      v_ext;

  assign h_ext = {1'b0, hor_count};
  assign v_ext = {1'b0, ver_count};

  // Trackers always describe the brick the counter is in or approaching next.
  always_ff @(posedge CLK_25MH) begin
    if (reset || line_end) begin
      col_idx <= '0;
      col_lo  <= COL_X0;
    end else if ((col_idx < COL_LIMIT) && (h_ext == col_lo + COL_LASTO)) begin
      col_idx <= col_idx + 1'b1;
      col_lo  <= col_lo + COL_PITCH;
    end
  end

  always_ff @(posedge CLK_25MH) begin
    if (reset || frame_end) begin
      row_idx  <= '0;
      row_base <= '0;
      row_lo   <= ROW_Y0;
    end else if (line_end && (row_idx < ROW_LIMIT) && (v_ext == row_lo + ROW_LASTO)) begin
      row_idx  <= row_idx + 1'b1;
      row_base <= row_base + ROW_STEP;
      row_lo   <= row_lo + ROW_STRD;
    end
  end

  logic             s0_grid;
  logic             s0_ball;
  logic             s0_paddle;
  logic             s0_active;
  logic [IDX_W-1:0] s0_idx;
  logic [10:0]      ball_x_e;
  logic [10:0]      ball_y_e;
  logic [10:0]      paddle_e;

  assign ball_x_e  = {1'b0, ball_x_q};
  assign ball_y_e  = {1'b0, ball_y_q};
  assign paddle_e  = {1'b0, paddle_q};
  assign s0_grid   = (col_idx < COL_LIMIT) && (row_idx < ROW_LIMIT)
                  && (h_ext >= col_lo) && (h_ext < col_lo + COL_W)
                  && (v_ext >= row_lo) && (v_ext < row_lo + ROW_H);
  assign s0_ball   = (h_ext >= ball_x_e) && (h_ext < ball_x_e + BALL_SZ)
                  && (v_ext >= ball_y_e) && (v_ext < ball_y_e + BALL_SZ);
  assign s0_paddle = (h_ext >= paddle_e) && (h_ext < paddle_e + PAD_W)
                  && (v_ext >= PAD_Y0) && (v_ext < PAD_Y1);
  assign s0_active = (h_ext < H_VIS) && (v_ext < V_VIS);
  assign s0_idx    = row_base + col_idx;

  logic             s1_grid;
  logic             s1_ball;
  logic             s1_paddle;
  logic             s1_active;
  logic [IDX_W-1:0] s1_idx;
  logic [2:0]       s1_row;
  logic             s1_hsync;
  logic             s1_vsync;

  always_ff @(posedge CLK_25MH) begin
    if (reset) begin
      s1_grid   <= 1'b0;
      s1_ball   <= 1'b0;
      s1_paddle <= 1'b0;
      s1_active <= 1'b0;
      s1_idx    <= '0;
      s1_row    <= '0;
      s1_hsync  <= 1'b1;
      s1_vsync  <= 1'b1;
    end else begin
      s1_grid   <= s0_grid;
      s1_ball   <= s0_ball;
      s1_paddle <= s0_paddle;
      s1_active <= s0_active;
      s1_idx    <= s0_idx;
      s1_row    <= row_idx[2:0];
      s1_hsync  <= hsync_raw;
      s1_vsync  <= vsync_raw;
    end
  end

  // Sized to the full index space so every position decodes; slots past the
  // grid are never written and read back as fresh.
  brick_state_e bricks [2**IDX_W];

  always_ff @(posedge CLK_25MH) begin
    if (reset) begin
      for (int i = 0; i < 2**IDX_W; i++) bricks[i] <= BRICK_FRESH;
    end else if (bus.active_write_enable && ({1'b0, bus.active_position} < BRICK_COUNT)) begin
      bricks[bus.active_position] <= brick_state_e'(bus.active_data);
    end
  end

  brick_state_e s2_state;
  logic [5:0]   s2_pixel;

  always_comb begin
    s2_state = bricks[s1_idx];
    s2_pixel = COLOR_BG;
    if (!s1_active) begin
      s2_pixel = COLOR_BG;
    end else if (s1_paddle) begin
      s2_pixel = COLOR_PADDLE;
    end else if (s1_ball) begin
      s2_pixel = COLOR_BALL;
    end else if (s1_grid && (s2_state != BRICK_DEAD)) begin
      s2_pixel = row_color(s1_row) + {4'b0000, 2'(s2_state)};
    end
  end

  always_ff @(posedge CLK_25MH) begin
    if (reset) begin
      bus.RGB   <= '0;
      bus.hsync <= 1'b1;
      bus.vsync <= 1'b1;
    end else begin
      bus.RGB   <= s2_pixel;
      bus.hsync <= s1_hsync;
      bus.vsync <= s1_vsync;
    end
  end

endmodule

// File: tb/tb_breakout_vga_renderer.sv
// Directed bench for breakout_vga_renderer on a shrunken raster
// (192 x 72 total, 160 x 64 visible) with hand-computed pixel expectations.
module tb_breakout_vga_renderer;

  localparam logic [5:0] RC0      = 6'b110000;
  localparam logic [5:0] RC1      = 6'b110100;
  localparam logic [5:0] RC2_HIT1 = 6'b111101;
  localparam logic [5:0] RC3      = 6'b001100;
  localparam logic [5:0] PADDLE   = 6'b100001;
  localparam logic [5:0] BALL     = 6'b111000;
  localparam int FRAME_CYCLES     = 192 * 72;

  logic CLK_25MH = 1'b0;
  logic reset    = 1'b1;

  breakout_vga_renderer_if #(.IDX_W(6)) bus ();

  breakout_vga_renderer #(
    .H_ACTIVE(160), .H_FP(8), .H_SYNC(16), .H_BP(8),
    .V_ACTIVE(64), .V_FP(4), .V_SYNC(2), .V_BP(2),
    .NUM_ROWS(5), .NUM_COLS(5),
    .BRICK_X0(8), .BRICK_W(20), .BRICK_GAP_X(10),
    .BRICK_Y0(4), .BRICK_H(6), .ROW_PITCH(10),
    .BALL_SIZE(4), .PADDLE_W(20), .PADDLE_Y(56), .PADDLE_H(4),
    .IDX_W(6)
  ) dut (
    .CLK_25MH(CLK_25MH),
    .reset   (reset),
    .bus     (bus)
  );

  always #20 CLK_25MH = ~CLK_25MH;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;
  int fsLast     = 0;
  int fsPeriod   = 0;

  always @(posedge CLK_25MH) cyc++;

  always @(negedge CLK_25MH) begin
    if (bus.frame_start === 1'b1) begin
      fsPeriod = cyc - fsLast;
      fsLast   = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic waitPixel(input string tag, input int h, input int v, output bit found);
    int budget;
    found  = 1'b0;
    budget = 0;
    while (!found && budget < 20000) begin
      @(negedge CLK_25MH);
      budget++;
      if (bus.hor_count == 10'(h) && bus.ver_count == 10'(v)) found = 1'b1;
    end
    vectors++;
    assert (found === 1'b1) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed timeout expected pixel (%0d,%0d)", tag, h, v);
    end
    if (found) begin
      @(posedge CLK_25MH);
      @(posedge CLK_25MH);
      @(negedge CLK_25MH);
    end
  endtask

  task automatic checkPixel(input string tag, input int h, input int v, input logic [5:0] expRgb);
    bit found;
    waitPixel(tag, h, v, found);
    if (found) checkOutput(tag, 32'(bus.RGB), 32'(expRgb));
  endtask

  task automatic checkSync(input string tag, input int h, input int v, input logic expH, input logic expV);
    bit found;
    waitPixel(tag, h, v, found);
    if (found) checkOutput(tag, {30'd0, bus.hsync, bus.vsync}, {30'd0, expH, expV});
  endtask

  task automatic applyStimulus(input int pos, input int data);
    @(negedge CLK_25MH);
    bus.active_write_enable = 1'b1;
    bus.active_position     = 6'(pos);
    bus.active_data         = 2'(data);
    @(negedge CLK_25MH);
    bus.active_write_enable = 1'b0;
  endtask

  initial begin
    int lowCount;
    bit found;
    bus.ball_x              = 10'd100;
    bus.ball_y              = 10'd30;
    bus.paddle_pos          = 10'd60;
    bus.active_write_enable = 1'b0;
    bus.active_position     = '0;
    bus.active_data         = '0;

    repeat (4) @(negedge CLK_25MH);
    checkOutput("rst_hor",   32'(bus.hor_count), 32'd0);
    checkOutput("rst_ver",   32'(bus.ver_count), 32'd0);
    checkOutput("rst_sync",  {30'd0, bus.hsync, bus.vsync}, 32'd3);
    checkOutput("rst_rgb",   32'(bus.RGB), 32'd0);
    checkOutput("rst_fs",    32'(bus.frame_start), 32'd0);
    reset = 1'b0;

    // Frame 0: latched ball/paddle are still the reset zeros.
    applyStimulus(7, 3);
    applyStimulus(12, 1);
    applyStimulus(40, 3);
    checkPixel("ball_latched_zero", 1, 1, BALL);
    checkPixel("col0_left_out", 7, 4, 6'd0);
    checkPixel("col0_left_in", 8, 4, RC0);
    checkPixel("col0_right_in", 27, 4, RC0);
    checkPixel("col0_right_out", 28, 4, 6'd0);
    checkPixel("row0_bottom_in", 10, 9, RC0);
    checkPixel("row0_bottom_out", 10, 10, 6'd0);
    checkPixel("idx6_live", 40, 15, RC1);
    checkPixel("idx7_dead", 70, 15, 6'd0);
    checkPixel("idx8_untouched", 100, 15, RC1);
    checkPixel("idx12_hit1", 70, 25, RC2_HIT1);
    checkSync("hsync_167", 167, 30, 1'b1, 1'b1);
    checkSync("hsync_168", 168, 31, 1'b0, 1'b1);
    checkSync("hsync_183", 183, 32, 1'b0, 1'b1);
    checkSync("hsync_184", 184, 33, 1'b1, 1'b1);
    lowCount = 0;
    repeat (192) begin
      @(negedge CLK_25MH);
      if (bus.hsync === 1'b0) lowCount++;
    end
    checkOutput("hsync_low_per_line", 32'(lowCount), 32'd16);
    checkSync("vsync_67", 0, 67, 1'b1, 1'b1);
    checkSync("vsync_68", 0, 68, 1'b1, 1'b0);
    checkSync("vsync_69", 0, 69, 1'b1, 1'b0);
    checkSync("vsync_70", 0, 70, 1'b1, 1'b1);

    // Frame 1: ball (100,30), paddle 60; ball input moves mid-frame.
    waitPixel("frame1_line20", 0, 20, found);
    bus.ball_x = 10'd130;
    checkPixel("ball_old_pos", 101, 31, BALL);
    checkPixel("ball_not_moved_yet", 131, 31, 6'd0);
    checkPixel("paddle_left_out", 59, 57, 6'd0);
    checkPixel("paddle_in", 62, 57, PADDLE);
    checkPixel("paddle_right_out", 80, 57, 6'd0);
    checkPixel("paddle_bottom_in", 79, 59, PADDLE);
    checkPixel("paddle_bottom_out", 79, 60, 6'd0);

    // Frame 2: ball now at (130,30).
    checkPixel("ball_gone_old", 101, 31, 6'd0);
    checkPixel("ball_left_out", 129, 31, 6'd0);
    checkPixel("ball_new_pos", 131, 31, BALL);
    checkPixel("ball_corner_in", 133, 33, BALL);
    checkPixel("ball_right_out", 134, 33, 6'd0);
    checkPixel("brick_below_ball", 131, 34, RC3);
    checkOutput("frame_period", 32'(fsPeriod), 32'(FRAME_CYCLES));
    bus.ball_x = 10'd62;
    bus.ball_y = 10'd56;

    // Frame 3: ball fully overlapping paddle.
    checkPixel("above_paddle", 60, 55, 6'd0);
    checkPixel("paddle_over_ball_tl", 62, 56, PADDLE);
    checkPixel("paddle_beside_ball", 66, 57, PADDLE);
    checkPixel("paddle_over_ball_br", 65, 59, PADDLE);

    // Mid-line reset with a simultaneous brick write.
    waitPixel("reset_point", 50, 10, found);
    @(negedge CLK_25MH);
    reset                   = 1'b1;
    bus.active_write_enable = 1'b1;
    bus.active_position     = 6'd0;
    bus.active_data         = 2'd3;
    @(negedge CLK_25MH);
    checkOutput("midrst_hor",  32'(bus.hor_count), 32'd0);
    checkOutput("midrst_ver",  32'(bus.ver_count), 32'd0);
    checkOutput("midrst_sync", {30'd0, bus.hsync, bus.vsync}, 32'd3);
    checkOutput("midrst_rgb",  32'(bus.RGB), 32'd0);
    reset                   = 1'b0;
    bus.active_write_enable = 1'b0;
    checkPixel("post_rst_ball_zero", 1, 1, BALL);
    checkPixel("idx0_write_blocked", 10, 5, RC0);
    checkPixel("idx7_cleared", 70, 15, RC1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/breakout_vga_renderer.md
Name: breakout_vga_renderer

Overview:
- Parametrised next-generation VGA renderer for the Breakout FPGA design.
- Generates 640x480-class raster timing on CLK_25MH and draws background, an R x C brick grid with per-brick hit state, the ball and the paddle.
- Successor features: configurable timing, grid size and colours; brick lookup via running column/row trackers (no per-pixel loop over all bricks); 2-stage registered pixel pipeline with sync outputs aligned to RGB; ball/paddle positions latched once per frame (tear-free).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- NUM_ROWS, 5, brick rows
- NUM_COLS, 5, brick columns
- BRICK_X0, 40, left edge of column 0
- BRICK_W, 80, brick width
- BRICK_GAP_X, 40, horizontal gap between bricks
- BRICK_Y0, 40, top edge of row 0
- BRICK_H, 30, brick height
- ROW_PITCH, 50, row-to-row distance
- BALL_SIZE, 8, ball square side
- PADDLE_W, 100, paddle width
- PADDLE_Y, 440, paddle top line
- PADDLE_H, 10, paddle height
- IDX_W, 6, brick index width; must satisfy 2^IDX_W >= NUM_ROWS*NUM_COLS

Ports:
- CLK_25MH input 1 pixel clock
- reset input 1 synchronous, active-high
- hsync output 1 active-low horizontal sync
- vsync output 1 active-low vertical sync
- RGB output 6 pixel colour {R2,G2,B2}
- hor_count output 10 stage-0 horizontal counter
- ver_count output 10 stage-0 vertical counter
- frame_start output 1 one-cycle pulse at h=0, v=V_ACTIVE
- paddle_pos input 10 paddle left x
- ball_x input 10 ball left x
- ball_y input 10 ball top y
- active_write_enable input 1 brick state write strobe
- active_position input IDX_W brick index = row*NUM_COLS+col
- active_data input 2 brick state: 0..2 = hits taken, 3 = destroyed

Behaviour:
- Reset (synchronous; wins over every other input): counters 0; hsync=vsync=1; RGB=0; frame_start=0; all brick states 0; latched ball/paddle values 0; pipeline registers cleared.
- Counters: h wraps at H_TOTAL-1 to 0 (H_TOTAL = sum of H params), with v incrementing at the wrap; v wraps at V_TOTAL-1 to 0.
- Sync: hsync low while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; vsync uses the same rule with V params. Defaults give h 656..751 and v 490..491.
- Latency: RGB, hsync and vsync for counter value (h,v) appear exactly 2 cycles after hor_count/ver_count show (h,v). Sync is delayed through the same pipe.
- Frame latch: in the cycle frame_start=1, capture ball_x, ball_y and paddle_pos. Only the latched copies are used for drawing.
- Geometry (all ranges half-open [lo, hi)):
  - Column c spans x in [BRICK_X0 + c*(BRICK_W+BRICK_GAP_X), +BRICK_W).
  - Row r spans y in [BRICK_Y0 + r*ROW_PITCH, +BRICK_H).
  - Ball spans [bx, bx+BALL_SIZE) x [by, by+BALL_SIZE).
  - Paddle spans [px, px+PADDLE_W) x [PADDLE_Y, PADDLE_Y+PADDLE_H).
  - All comparisons use 11-bit sums so that no range wraps.
- Brick tracking: the column tracker resets at h=0 and advances on boundary compares; the row tracker resets at v=0 and advances at line end. No multiply or divide is used per pixel.
- Pipeline stages:
  - Stage 1 registers: inside-grid flag, brick index, ball hit, paddle hit.
  - Stage 2 reads brick state and drives RGB.
- Colour priority: outside the active area -> 0; else paddle 6'b100001 > ball 6'b111000 > live brick (state != 3), coloured ROW_COLOR[r] + state (mod 64) > background 0.
- Brick writes: take effect the cycle after the strobe. A stage-2 read in the same cycle sees the old value. A write with active_position >= NUM_ROWS*NUM_COLS is ignored.
- Reset asserted mid-line: outputs are at reset values on the next edge; the raster restarts at (0,0).

Decomposition:
- breakout_pkg holds: default timing constants; brick state encoding (BRICK_DEAD = 2'd3); colour constants (paddle, ball, background, ROW_COLOR table indexed by row mod 8).
- One sub-module, vga_timing_gen: counters, sync generation and frame_start; parametrised by the timing parameters.

Test Plan:
- Release reset, run 2 frames -> hsync low for 96 cycles every 800; vsync low for lines 490-491 of every 525; frame_start once per 420000 cycles.
- Counter at (0,0) -> RGB/hsync for that pixel appear 2 cycles later. hor_count=656 -> hsync=0 exactly 2 cycles later.
- Write state 3 to index 7 (row 1, col 2) -> pixel (290,95) renders 0; index 6 at (170,95) renders ROW_COLOR[1].
- Change ball_x from 100 to 300 while v=200 -> frame stays at 100 until the next frame_start, then moves to 300.
- Paddle at 280, ball at (300,442) -> pixel (302,444) = 6'b100001; pixel (300,440) with ball at (300,440) is also paddle colour.
- reset plus write of index 0 in the same cycle -> state 0. Write to index 40 -> no brick changes.
